// File: rtl/mips_decode_stage.sv
// Decode stage of the 5-stage MIPS pipeline: 32x32 register file, R/I/J decode,
// load-use hazard detection and the ID/EX pipeline register feeding execute.
module mips_decode_stage #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [PC_W-1:0]   f_pc,
    input  logic [31:0]       f_ir,
    output logic              d_stall,
    input  logic              x_flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              x_valid,
    output logic [PC_W-1:0]   x_pc,
    output logic [DATA_W-1:0] x_rs_val,
    output logic [DATA_W-1:0] x_rt_val,
    output logic [DATA_W-1:0] x_imm,
    output logic [4:0]        x_rd,
    output logic [2:0]        x_alu_func,
    output logic              x_alu_src,
    output logic              x_reg_we,
    output logic              x_mem_rd,
    output logic              x_mem_wr,
    output logic              x_branch,
    output logic              x_bne,
    output logic              x_jump,
    output logic [PC_W-1:0]   x_jtarget,
    output logic              x_illegal
);

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_PASSB = 3'b101
    } alu_func_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rd;
        alu_func_t         func;
        logic              alu_src;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
        logic              branch;
        logic              bne;
        logic              jump;
        logic [PC_W-1:0]   jtarget;
        logic              illegal;
    } idex_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic [4:0] rd_addr;

    assign opcode  = f_ir[31:26];
    assign rs_addr = f_ir[25:21];
    assign rt_addr = f_ir[20:16];
    assign rd_addr = f_ir[15:11];
    assign funct   = f_ir[5:0];

    // ---------------- register file ----------------
    logic [DATA_W-1:0] regs [32];

    // NOTE: the register file is cleared by reset, which forces it into flops
    // rather than a RAM macro; that is the price of a defined post-reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Write-through lets an instruction see a value retiring in the same cycle.
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    always_comb begin
        rs_val = regs[rs_addr];
        rt_val = regs[rt_addr];
        if (wb_we && (wb_addr == rs_addr)) rs_val = wb_data;
        if (wb_we && (wb_addr == rt_addr)) rt_val = wb_data;
        if (rs_addr == 5'd0) rs_val = '0;
        if (rt_addr == 5'd0) rt_val = '0;
    end

    // ---------------- instruction decode ----------------
    idex_t dec;
    logic  reads_rt;

    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        dec              = '0;
        reads_rt         = 1'b0;
        dec.valid        = 1'b1;
        dec.pc           = f_pc;
        dec.rs_val       = rs_val;
        dec.rt_val       = rt_val;
        dec.imm          = {{(DATA_W-16){f_ir[15]}}, f_ir[15:0]};
        dec.rd           = rt_addr;
        dec.func         = ALU_ADD;
        dec.jtarget      = f_pc;
        dec.jtarget[27:0] = {f_ir[25:0], 2'b00};

        case (opcode)
            OP_RTYPE: begin
                reads_rt   = 1'b1;
                dec.rd     = rd_addr;
                dec.reg_we = 1'b1;
                case (funct)
                    FN_ADD:  dec.func = ALU_ADD;
                    FN_SUB:  dec.func = ALU_SUB;
                    FN_AND:  dec.func = ALU_AND;
                    FN_OR:   dec.func = ALU_OR;
                    FN_SLT:  dec.func = ALU_SLT;
                    default: begin
                        dec.reg_we  = 1'b0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
            end
            OP_SLTI: begin
                dec.func    = ALU_SLT;
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
            end
            OP_ANDI: begin
                dec.func    = ALU_AND;
                dec.imm     = {{(DATA_W-16){1'b0}}, f_ir[15:0]};
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
            end
            OP_ORI: begin
                dec.func    = ALU_OR;
                dec.imm     = {{(DATA_W-16){1'b0}}, f_ir[15:0]};
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
            end
            OP_LUI: begin
                dec.func    = ALU_PASSB;
                dec.imm     = {f_ir[15:0], {(DATA_W-16){1'b0}}};
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
            end
            OP_LW: begin
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
                dec.mem_rd  = 1'b1;
            end
            OP_SW: begin
                reads_rt    = 1'b1;
                dec.alu_src = 1'b1;
                dec.mem_wr  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                reads_rt   = 1'b1;
                dec.func   = ALU_SUB;
                dec.branch = 1'b1;
                dec.bne    = (opcode == OP_BNE);
            end
            OP_J: begin
                dec.rd   = 5'd0;
                dec.jump = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ---------------- hazard / bubble control ----------------
    idex_t q;
    logic  load_use;
    logic  bubble;

    // A load in EX cannot forward in time for a consumer now in decode.
    assign load_use = q.valid && q.mem_rd && (q.rd != 5'd0) && f_valid &&
                      ((q.rd == rs_addr) || ((q.rd == rt_addr) && reads_rt));
    assign d_stall  = load_use && !x_flush;
    assign bubble   = x_flush || !f_valid || load_use;

    // NOTE: pipeline state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= bubble ? idex_t'('0) : dec;
    end

    assign x_valid    = q.valid;
    assign x_pc       = q.pc;
    assign x_rs_val   = q.rs_val;
    assign x_rt_val   = q.rt_val;
    assign x_imm      = q.imm;
    assign x_rd       = q.rd;
    assign x_alu_func = q.func;
    assign x_alu_src  = q.alu_src;
    assign x_reg_we   = q.reg_we;
    assign x_mem_rd   = q.mem_rd;
    assign x_mem_wr   = q.mem_wr;
    assign x_branch   = q.branch;
    assign x_bne      = q.bne;
    assign x_jump     = q.jump;
    assign x_jtarget  = q.jtarget;
    assign x_illegal  = q.illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Self-checking bench for mips_decode_stage: a table of decode vectors plus
// hand-written sequences for reset, write-through, load-use stall and flush.
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_ir;
    logic        d_stall;
    logic        x_flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        x_valid;
    logic [31:0] x_pc;
    logic [31:0] x_rs_val;
    logic [31:0] x_rt_val;
    logic [31:0] x_imm;
    logic [4:0]  x_rd;
    logic [2:0]  x_alu_func;
    logic        x_alu_src;
    logic        x_reg_we;
    logic        x_mem_rd;
    logic        x_mem_wr;
    logic        x_branch;
    logic        x_bne;
    logic        x_jump;
    logic [31:0] x_jtarget;
    logic        x_illegal;

    mips_decode_stage #(.PC_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_ir(f_ir),
        .d_stall(d_stall), .x_flush(x_flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .x_valid(x_valid), .x_pc(x_pc), .x_rs_val(x_rs_val), .x_rt_val(x_rt_val),
        .x_imm(x_imm), .x_rd(x_rd), .x_alu_func(x_alu_func), .x_alu_src(x_alu_src),
        .x_reg_we(x_reg_we), .x_mem_rd(x_mem_rd), .x_mem_wr(x_mem_wr),
        .x_branch(x_branch), .x_bne(x_bne), .x_jump(x_jump),
        .x_jtarget(x_jtarget), .x_illegal(x_illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [6:0] ctl_now();
        return {x_reg_we, x_mem_rd, x_mem_wr, x_branch, x_bne, x_jump, x_illegal};
    endfunction

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        f_valid = 1'b0;
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_we   = 1'b0;
    endtask

    // control bundle: {reg_we, mem_rd, mem_wr, branch, bne, jump, illegal}
    localparam logic [6:0] C_ALU = 7'b1000000;
    localparam logic [6:0] C_LW  = 7'b1100000;
    localparam logic [6:0] C_SW  = 7'b0010000;
    localparam logic [6:0] C_BEQ = 7'b0001000;
    localparam logic [6:0] C_BNE = 7'b0001100;
    localparam logic [6:0] C_J   = 7'b0000010;
    localparam logic [6:0] C_ILL = 7'b0000001;
    localparam logic [6:0] C_OFF = 7'b0000000;

    // check mask: [3] operands, [2] immediate, [1] destination, [0] alu func/src
    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [3:0]  chk;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  func;
        logic        src;
        logic [6:0]  ctl;
        logic [31:0] jt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        // Preloaded registers: r5=12345678, r9=0F0F00FF, r10=00000010, others 0.
        vecs[0]  = '{rtype(5, 9, 1, 6'h20),  32'h1000, 4'b1011, 32'h12345678, 32'h0F0F00FF, 32'h0, 5'd1, 3'd0, 1'b0, C_ALU, 32'h0};
        vecs[1]  = '{rtype(9, 5, 2, 6'h22),  32'h1004, 4'b1011, 32'h0F0F00FF, 32'h12345678, 32'h0, 5'd2, 3'd1, 1'b0, C_ALU, 32'h0};
        vecs[2]  = '{rtype(5, 9, 3, 6'h24),  32'h1008, 4'b1011, 32'h12345678, 32'h0F0F00FF, 32'h0, 5'd3, 3'd2, 1'b0, C_ALU, 32'h0};
        vecs[3]  = '{rtype(5, 9, 4, 6'h25),  32'h100C, 4'b1011, 32'h12345678, 32'h0F0F00FF, 32'h0, 5'd4, 3'd3, 1'b0, C_ALU, 32'h0};
        vecs[4]  = '{rtype(9, 10, 6, 6'h2A), 32'h1010, 4'b1011, 32'h0F0F00FF, 32'h00000010, 32'h0, 5'd6, 3'd4, 1'b0, C_ALU, 32'h0};
        vecs[5]  = '{32'h20A6FFFF,           32'h1014, 4'b1111, 32'h12345678, 32'h0, 32'hFFFFFFFF, 5'd6, 3'd0, 1'b1, C_ALU, 32'h0};
        vecs[6]  = '{itype(6'h0C, 9, 7, 16'h8001),  32'h1018, 4'b1111, 32'h0F0F00FF, 32'h0, 32'h00008001, 5'd7, 3'd2, 1'b1, C_ALU, 32'h0};
        vecs[7]  = '{itype(6'h0D, 10, 8, 16'hFFFF), 32'h101C, 4'b1111, 32'h00000010, 32'h0, 32'h0000FFFF, 5'd8, 3'd3, 1'b1, C_ALU, 32'h0};
        vecs[8]  = '{itype(6'h0A, 5, 11, 16'h8000), 32'h1020, 4'b1111, 32'h12345678, 32'h0, 32'hFFFF8000, 5'd11, 3'd4, 1'b1, C_ALU, 32'h0};
        vecs[9]  = '{itype(6'h0F, 0, 7, 16'hBEEF),  32'h1024, 4'b1111, 32'h0, 32'h0, 32'hBEEF0000, 5'd7, 3'd5, 1'b1, C_ALU, 32'h0};
        vecs[10] = '{itype(6'h23, 10, 12, 16'h0008), 32'h1028, 4'b1111, 32'h00000010, 32'h0, 32'h00000008, 5'd12, 3'd0, 1'b1, C_LW, 32'h0};
        vecs[11] = '{itype(6'h2B, 5, 9, 16'hFFFC),  32'h102C, 4'b1111, 32'h12345678, 32'h0F0F00FF, 32'hFFFFFFFC, 5'd9, 3'd0, 1'b1, C_SW, 32'h0};
        vecs[12] = '{itype(6'h04, 5, 9, 16'hFFFE),  32'h1030, 4'b1111, 32'h12345678, 32'h0F0F00FF, 32'hFFFFFFFE, 5'd9, 3'd1, 1'b0, C_BEQ, 32'h0};
        vecs[13] = '{itype(6'h05, 9, 10, 16'h0003), 32'h1034, 4'b1111, 32'h0F0F00FF, 32'h00000010, 32'h00000003, 5'd10, 3'd1, 1'b0, C_BNE, 32'h0};
        vecs[14] = '{{6'h02, 26'h0000010}, 32'hA0000100, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_J, 32'hA0000040};
        vecs[15] = '{{6'h02, 26'h0000010}, 32'h00000200, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_J, 32'h00000040};
        vecs[16] = '{{6'h3F, 26'h0},       32'h1040, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_ILL, 32'h0};
        vecs[17] = '{rtype(5, 9, 1, 6'h21), 32'h1044, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_ILL, 32'h0};

        rst = 1'b0; f_valid = 1'b1; f_pc = 32'h1234; f_ir = itype(6'h23, 1, 2, 16'h0);
        x_flush = 1'b0; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFFFFFF;

        // Reset holds every output at zero even with live inputs.
        tick(); tick();
        check("rst.valid", {31'd0, x_valid}, 32'd0);
        check("rst.ctl",   {25'd0, ctl_now()}, 32'd0);
        check("rst.pc",    x_pc, 32'd0);
        check("rst.rs",    x_rs_val, 32'd0);
        check("rst.imm",   x_imm, 32'd0);
        check("rst.rd",    {27'd0, x_rd}, 32'd0);
        check("rst.func",  {29'd0, x_alu_func}, 32'd0);
        check("rst.jt",    x_jtarget, 32'd0);
        check("rst.stall", {31'd0, d_stall}, 32'd0);
        wb_we = 1'b0;
        rst = 1'b1;

        for (int k = 1; k < 32; k++) begin
            f_ir = rtype(5'(k), 5'(32 - k), 5'd1, 6'h20);
            tick();
            check($sformatf("rd0.r%0d", k), x_rs_val, 32'd0);
            check($sformatf("rd0.r%0d", 32 - k), x_rt_val, 32'd0);
        end

        wb_write(5'd5, 32'h12345678);
        wb_write(5'd9, 32'h0F0F00FF);
        wb_write(5'd10, 32'h00000010);
        f_ir = itype(6'h23, 1, 2, 16'h0);
        tick();
        check("fval0.valid", {31'd0, x_valid}, 32'd0);
        check("fval0.ctl",   {25'd0, ctl_now()}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            f_valid = 1'b1;
            f_ir = vecs[i].ir;
            f_pc = vecs[i].pc;
            #1;
            check($sformatf("v%0d.stall", i), {31'd0, d_stall}, 32'd0);
            tick();
            check($sformatf("v%0d.valid", i), {31'd0, x_valid}, 32'd1);
            check($sformatf("v%0d.pc", i), x_pc, vecs[i].pc);
            check($sformatf("v%0d.ctl", i), {25'd0, ctl_now()}, {25'd0, vecs[i].ctl});
            if (vecs[i].chk[3]) begin
                check($sformatf("v%0d.rs", i), x_rs_val, vecs[i].rs_val);
                check($sformatf("v%0d.rt", i), x_rt_val, vecs[i].rt_val);
            end
            if (vecs[i].chk[2]) check($sformatf("v%0d.imm", i), x_imm, vecs[i].imm);
            if (vecs[i].chk[1]) check($sformatf("v%0d.rd", i), {27'd0, x_rd}, {27'd0, vecs[i].rd});
            if (vecs[i].chk[0]) begin
                check($sformatf("v%0d.func", i), {29'd0, x_alu_func}, {29'd0, vecs[i].func});
                check($sformatf("v%0d.src", i), {31'd0, x_alu_src}, {31'd0, vecs[i].src});
            end
            if (vecs[i].ctl[1]) check($sformatf("v%0d.jt", i), x_jtarget, vecs[i].jt);
        end

        // Write-through: value being written back is visible to decode at once.
        f_valid = 1'b1; f_pc = 32'h2000;
        f_ir = rtype(3, 0, 4, 6'h25);
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000A5A5;
        tick();
        check("byp.rs", x_rs_val, 32'h0000A5A5);
        check("byp.rt", x_rt_val, 32'd0);
        wb_we = 1'b0;
        tick();
        check("byp.stored", x_rs_val, 32'h0000A5A5);
        f_ir = rtype(0, 0, 1, 6'h20);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        tick();
        check("r0.bypass.rs", x_rs_val, 32'd0);
        check("r0.bypass.rt", x_rt_val, 32'd0);
        wb_we = 1'b0;
        tick();
        check("r0.stored", x_rs_val, 32'd0);

        // Load-use on rs/rt: one stall cycle, one bubble, then the consumer issues.
        f_ir = itype(6'h23, 1, 2, 16'h0);
        tick();
        check("lu.lw.mem_rd", {31'd0, x_mem_rd}, 32'd1);
        check("lu.lw.rd", {27'd0, x_rd}, 32'd2);
        f_ir = rtype(2, 2, 3, 6'h20);
        #1;
        check("lu.stall", {31'd0, d_stall}, 32'd1);
        tick();
        check("lu.bubble.valid", {31'd0, x_valid}, 32'd0);
        check("lu.bubble.ctl", {25'd0, ctl_now()}, 32'd0);
        check("lu.stall.clear", {31'd0, d_stall}, 32'd0);
        tick();
        check("lu.issue.valid", {31'd0, x_valid}, 32'd1);
        check("lu.issue.rd", {27'd0, x_rd}, 32'd3);
        check("lu.issue.ctl", {25'd0, ctl_now()}, {25'd0, C_ALU});

        // sw reads rt as store data, so a match on rt alone stalls.
        f_ir = itype(6'h23, 1, 2, 16'h0);
        tick();
        f_ir = itype(6'h2B, 1, 2, 16'h0004);
        #1;
        check("lu.sw.stall", {31'd0, d_stall}, 32'd1);
        tick();
        check("lu.sw.bubble", {31'd0, x_valid}, 32'd0);
        tick();
        check("lu.sw.issue", {25'd0, ctl_now()}, {25'd0, C_SW});

        // addi writes rt but does not read it: no stall.
        f_ir = itype(6'h23, 1, 2, 16'h0);
        tick();
        f_ir = itype(6'h08, 4, 2, 16'h0001);
        #1;
        check("lu.addi.nostall", {31'd0, d_stall}, 32'd0);
        tick();
        check("lu.addi.valid", {31'd0, x_valid}, 32'd1);
        check("lu.addi.rd", {27'd0, x_rd}, 32'd2);

        // Loads to r0 never create a hazard.
        f_ir = itype(6'h23, 1, 0, 16'h0);
        tick();
        f_ir = rtype(0, 0, 3, 6'h20);
        #1;
        check("lu.r0.nostall", {31'd0, d_stall}, 32'd0);
        tick();
        check("lu.r0.valid", {31'd0, x_valid}, 32'd1);

        // Empty IF/ID: no hazard check, bubble inserted.
        f_ir = itype(6'h23, 1, 2, 16'h0);
        tick();
        f_valid = 1'b0;
        f_ir = rtype(2, 2, 3, 6'h20);
        #1;
        check("fval0.nostall", {31'd0, d_stall}, 32'd0);
        tick();
        check("fval0.bubble", {31'd0, x_valid}, 32'd0);

        // Flush beats stall.
        f_valid = 1'b1;
        f_ir = itype(6'h23, 1, 2, 16'h0);
        tick();
        f_ir = rtype(2, 2, 3, 6'h20);
        x_flush = 1'b1;
        #1;
        check("flush.nostall", {31'd0, d_stall}, 32'd0);
        tick();
        check("flush.valid", {31'd0, x_valid}, 32'd0);
        check("flush.ctl", {25'd0, ctl_now()}, 32'd0);
        x_flush = 1'b0;

        // Asynchronous reset mid-operation clears ID/EX and the register file.
        f_ir = rtype(5, 5, 1, 6'h20);
        tick();
        check("mid.pre.rs", x_rs_val, 32'h12345678);
        #3;
        rst = 1'b0;
        #1;
        check("mid.async.valid", {31'd0, x_valid}, 32'd0);
        check("mid.async.rs", x_rs_val, 32'd0);
        check("mid.async.stall", {31'd0, d_stall}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mid.post.valid", {31'd0, x_valid}, 32'd1);
        check("mid.post.rs", x_rs_val, 32'd0);
        check("mid.post.rd", {27'd0, x_rd}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
